// File: rtl/count_cycle_mc.sv
// count_cycle_mc
// Tags every accepted input beat with a channel index and a frame-relative count.
// The input stream carries NUM_CHAN channels interleaved sample by sample. Tagged beats
// pass through two register stages into a first-word-fall-through FIFO.
//
// Ports:
//   clk, async_reset_n     clock, asynchronous active-low reset (release synchronised)
//   s_axis_*               input stream (tvalid/tdata/tready)
//   start_sig, cnt_limit   frame restart request and per-frame last count, both qualified
//                          by an accepted beat
//   af                     FIFO occupancy >= AF_THRESH (registered)
//   m_axis_*               output stream: tdata, chan, count, tlast, tvalid/tready
module count_cycle_mc #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned NUM_CHAN   = 4,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned AF_THRESH  = 16,
  localparam int unsigned CHAN_W    = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1
) (
  input  logic                  clk,
  input  logic                  async_reset_n,
  input  logic                  s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  output logic                  s_axis_tready,
  input  logic                  start_sig,
  input  logic [CNT_WIDTH-1:0]  cnt_limit,
  output logic                  af,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [CHAN_W-1:0]     m_axis_chan,
  output logic [CNT_WIDTH-1:0]  m_axis_count,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam int unsigned OccW  = ADDR_WIDTH + 1;
  localparam logic [CHAN_W-1:0] ChanMax = CHAN_W'(NUM_CHAN - 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [CHAN_W-1:0]     chan;
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  last;
  } beat_t;

  // Reset release synchroniser; input is held off until two edges after release.
  logic rst_s1_q, rst_s2_q;

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      rst_s1_q <= 1'b0;
      rst_s2_q <= 1'b0;
    end else begin
      rst_s1_q <= 1'b1;
      rst_s2_q <= rst_s1_q;
    end
  end

  // Frame tracking state: tags of the most recent accepted beat.
  logic [CHAN_W-1:0]    chan_q, chan_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] lim_q, lim_d;
  logic                 startup_q, startup_d;
  logic                 last_q, last_d;

  logic                 s0_vld_q, s0_vld_d, s1_vld_q, s1_vld_d;
  beat_t                s0_q, s0_d, s1_q, s1_d;

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d, wvis_q, rptr_q, rptr_d;
  logic [OccW-1:0]       occ_q, occ_d;
  logic                  af_q, af_d;
  beat_t                 mem_q [Depth];
  beat_t                 rd_beat;

  logic                  take, wr, rd, frame_start;
  logic [OccW:0]         pending;
  logic [CHAN_W-1:0]     beat_chan;
  logic [CNT_WIDTH-1:0]  beat_cnt, beat_lim;
  logic                  beat_last;

  // Outstanding beats (FIFO plus pipeline) are capped at Depth-1 so a full pipeline
  // can always land in the FIFO without stalling.
  assign pending       = {1'b0, occ_q} + {{OccW{1'b0}}, s0_vld_q} + {{OccW{1'b0}}, s1_vld_q};
  assign s_axis_tready = rst_s2_q & (pending < (OccW + 1)'(Depth - 1));
  assign take          = s_axis_tvalid & s_axis_tready;

  // Stage 0: tag computation for the beat being accepted.
  always_comb begin
    frame_start = startup_q | start_sig | last_q;
    if (frame_start) begin
      beat_chan = '0;
      beat_cnt  = '0;
      beat_lim  = cnt_limit;
    end else if (chan_q == ChanMax) begin
      beat_chan = '0;
      beat_cnt  = cnt_q + CNT_WIDTH'(1);
      beat_lim  = lim_q;
    end else begin
      beat_chan = chan_q + CHAN_W'(1);
      beat_cnt  = cnt_q;
      beat_lim  = lim_q;
    end
    beat_last = (beat_chan == ChanMax) && (beat_cnt == beat_lim);

    chan_d    = chan_q;
    cnt_d     = cnt_q;
    lim_d     = lim_q;
    startup_d = startup_q;
    last_d    = last_q;
    s0_d      = s0_q;
    if (take) begin
      chan_d    = beat_chan;
      cnt_d     = beat_cnt;
      lim_d     = beat_lim;
      startup_d = 1'b0;
      last_d    = beat_last;
      s0_d      = '{data: s_axis_tdata, chan: beat_chan, cnt: beat_cnt, last: beat_last};
    end
    s0_vld_d = take;

    // Stage 1 only moves when stage 0 held a beat; no back-pressure needed.
    s1_vld_d = s0_vld_q;
    s1_d     = s0_vld_q ? s0_q : s1_q;
  end

  // FIFO. A written entry becomes visible one cycle later through wvis_q.
  assign wr            = s1_vld_q;
  assign m_axis_tvalid = (rptr_q != wvis_q);
  assign rd            = m_axis_tvalid & m_axis_tready;
  assign rd_beat       = m_axis_tvalid ? mem_q[rptr_q] : '0;
  assign m_axis_tdata  = rd_beat.data;
  assign m_axis_chan   = rd_beat.chan;
  assign m_axis_count  = rd_beat.cnt;
  assign m_axis_tlast  = rd_beat.last;
  assign af            = af_q;

  always_comb begin
    wptr_d = wptr_q + ADDR_WIDTH'(wr);
    rptr_d = rptr_q + ADDR_WIDTH'(rd);
    occ_d  = occ_q + OccW'(wr) - OccW'(rd);
    af_d   = (occ_d >= OccW'(AF_THRESH));
  end

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      chan_q    <= '0;
      cnt_q     <= '0;
      lim_q     <= '0;
      startup_q <= 1'b1;
      last_q    <= 1'b0;
      s0_vld_q  <= 1'b0;
      s1_vld_q  <= 1'b0;
      s0_q      <= '0;
      s1_q      <= '0;
      wptr_q    <= '0;
      wvis_q    <= '0;
      rptr_q    <= '0;
      occ_q     <= '0;
      af_q      <= 1'b0;
    end else begin
      chan_q    <= chan_d;
      cnt_q     <= cnt_d;
      lim_q     <= lim_d;
      startup_q <= startup_d;
      last_q    <= last_d;
      s0_vld_q  <= s0_vld_d;
      s1_vld_q  <= s1_vld_d;
      s0_q      <= s0_d;
      s1_q      <= s1_d;
      wptr_q    <= wptr_d;
      wvis_q    <= wptr_q;
      rptr_q    <= rptr_d;
      occ_q     <= occ_d;
      af_q      <= af_d;
    end
  end

  // Storage needs no reset: empty pointers mask its contents.
  always_ff @(posedge clk) begin
    if (wr) begin
      mem_q[wptr_q] <= s1_q;
    end
  end

endmodule
